ternary_matvec_engine: RTL and testbench

- Consumes the ternary weight array produced by the weight loader and computes y = W^T·x for one streamed activation vector per run.
- Activations arrive one 8-bit signed element per accepted cycle.
- All output columns accumulate in parallel.
- Results are saturated to 8 bits and drained one column per cycle through a valid/ready handshake to the output pin stage.

---
 rtl/ternary_matvec_engine.sv | 148 ++++++++++++++
 tb/tb_ternary_matvec_engine.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ternary_matvec_engine.sv
// Ternary matrix-vector engine: streams x, accumulates y = W^T.x across all
// columns in parallel, then drains saturated 8-bit results one column per beat.
module ternary_matvec_engine #(
    parameter int MAX_IN_LEN  = 16,
    parameter int MAX_OUT_LEN = 8,
    parameter int ACC_W       = 13
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 ena,
    input  logic [6:0]                           i_param,
    input  logic [2*MAX_IN_LEN*MAX_OUT_LEN-1:0]  i_weights,
    input  logic                                 i_weights_ready,
    input  logic [7:0]                           i_data,
    input  logic                                 i_valid,
    output logic                                 o_in_ready,
    output logic [7:0]                           o_data,
    output logic                                 o_valid,
    output logic                                 o_last,
    input  logic                                 i_out_ready,
    output logic                                 o_busy
);

    localparam int IDX_W = $clog2(MAX_IN_LEN);
    localparam int K_W   = $clog2(MAX_OUT_LEN);

    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(127);
    localparam logic signed [ACC_W-1:0] SAT_LO = -ACC_W'(128);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_DRAIN
    } state_t;

    state_t                  r_state;
    logic signed [ACC_W-1:0] r_acc [MAX_OUT_LEN];
    logic [IDX_W-1:0]        r_idx;
    logic [IDX_W-1:0]        r_in_m1;
    logic [K_W-1:0]          r_k;
    logic [K_W-1:0]          r_out_m1;
    logic [7:0]              r_o_data;
    logic                    r_o_valid;
    logic                    r_o_last;

    logic                    w_accept;
    logic [IDX_W-1:0]        w_row;
    logic signed [ACC_W-1:0] w_x;
    logic [1:0]              w_code [MAX_OUT_LEN];
    logic signed [ACC_W-1:0] w_term [MAX_OUT_LEN];
    logic [K_W-1:0]          w_k_next;

    function automatic logic [7:0] sat8(input logic signed [ACC_W-1:0] v);
        if (v > SAT_HI)      return 8'h7f;
        else if (v < SAT_LO) return 8'h80;
        else                 return v[7:0];
    endfunction

    assign o_in_ready = ena && i_weights_ready &&
                        ((r_state == S_IDLE) || (r_state == S_ACCUM));
    assign w_accept   = i_valid && o_in_ready;
    assign w_k_next   = r_k + K_W'(1);

    assign o_data  = r_o_data;
    assign o_valid = r_o_valid;
    assign o_last  = r_o_last;
    assign o_busy  = (r_state != S_IDLE);

    // Weights are read live; the loader keeps them stable for the whole run.
    always_comb begin
        w_row = (r_state == S_IDLE) ? '0 : r_idx;
        w_x   = ACC_W'(signed'(i_data));
        for (int j = 0; j < MAX_OUT_LEN; j++) begin
            w_code[j] = i_weights[(int'(w_row) * MAX_OUT_LEN + j) * 2 +: 2];
            case (w_code[j])
                2'b01:   w_term[j] = w_x;
                2'b11:   w_term[j] = -w_x;
                default: w_term[j] = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_in_m1   <= '0;
            r_k       <= '0;
            r_out_m1  <= '0;
            r_o_data  <= '0;
            r_o_valid <= 1'b0;
            r_o_last  <= 1'b0;
            // NOTE: the accumulator array is small register state, not a RAM, so it resets like any flop.
            for (int j = 0; j < MAX_OUT_LEN; j++) r_acc[j] <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_in_m1  <= i_param[6:3];
                        r_out_m1 <= i_param[2:0];
                        r_k      <= '0;
                        for (int j = 0; j < MAX_OUT_LEN; j++) r_acc[j] <= w_term[j];
                        if (i_param[6:3] == '0) begin
                            r_idx   <= '0;
                            r_state <= S_DRAIN;
                        end else begin
                            r_idx   <= IDX_W'(1);
                            r_state <= S_ACCUM;
                        end
                    end
                end
                S_ACCUM: begin
                    if (w_accept) begin
                        for (int j = 0; j < MAX_OUT_LEN; j++) r_acc[j] <= r_acc[j] + w_term[j];
                        if (r_idx == r_in_m1) begin
                            r_k     <= '0;
                            r_state <= S_DRAIN;
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    // First drain cycle loads column 0; afterwards each handshake loads the next.
                    if (!r_o_valid) begin
                        r_o_valid <= 1'b1;
                        r_o_data  <= sat8(r_acc[r_k]);
                        r_o_last  <= (r_k == r_out_m1);
                    end else if (i_out_ready) begin
                        if (r_o_last) begin
                            r_o_valid <= 1'b0;
                            r_o_last  <= 1'b0;
                            r_k       <= '0;
                            r_idx     <= '0;
                            r_state   <= S_IDLE;
                        end else begin
                            r_k      <= w_k_next;
                            r_o_data <= sat8(r_acc[w_k_next]);
                            r_o_last <= (w_k_next == r_out_m1);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ternary_matvec_engine.sv
// Self-checking bench for ternary_matvec_engine: directed scenarios plus
// randomized runs scored against a plain-arithmetic dot-product model.
module tb_ternary_matvec_engine;

    localparam int MI = 16;
    localparam int MO = 8;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 ena;
    logic [6:0]           i_param;
    logic [2*MI*MO-1:0]   i_weights;
    logic                 i_weights_ready;
    logic [7:0]           i_data;
    logic                 i_valid;
    logic                 o_in_ready;
    logic [7:0]           o_data;
    logic                 o_valid;
    logic                 o_last;
    logic                 i_out_ready;
    logic                 o_busy;

    logic [1:0] wcode [MI][MO];
    int         xv [MI];
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    ternary_matvec_engine dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ena            (ena),
        .i_param        (i_param),
        .i_weights      (i_weights),
        .i_weights_ready(i_weights_ready),
        .i_data         (i_data),
        .i_valid        (i_valid),
        .o_in_ready     (o_in_ready),
        .o_data         (o_data),
        .o_valid        (o_valid),
        .o_last         (o_last),
        .i_out_ready    (i_out_ready),
        .o_busy         (o_busy)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic int wval(input logic [1:0] c);
        if (c == 2'b01) return 1;
        if (c == 2'b11) return -1;
        return 0;
    endfunction

    function automatic int sat(input int v);
        return (v > 127) ? 127 : (v < -128) ? -128 : v;
    endfunction

    task automatic set_all(input logic [1:0] c);
        for (int i = 0; i < MI; i++)
            for (int j = 0; j < MO; j++) wcode[i][j] = c;
    endtask

    task automatic pack_w();
        for (int i = 0; i < MI; i++)
            for (int j = 0; j < MO; j++) i_weights[(i*MO+j)*2 +: 2] = wcode[i][j];
    endtask

    // Called just after a negedge; returns just after the negedge following the accept edge.
    task automatic send(input string tag, input int x);
        int n = 0;
        i_data  = 8'(x);
        i_valid = 1'b1;
        #1;
        while (!o_in_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 50) check({tag, ".accept_timeout"}, 0, 1);
        @(posedge clk);
        @(negedge clk);
        i_valid = 1'b0;
    endtask

    task automatic run(input string tag, input int in_len, input int out_len,
                       input int gap_at, input int stall_col);
        int exp_y [MO];
        int s;
        int n;
        logic [7:0] held;
        for (int k = 0; k < out_len; k++) begin
            s = 0;
            for (int i = 0; i < in_len; i++) s += xv[i] * wval(wcode[i][k]);
            exp_y[k] = sat(s);
        end
        pack_w();
        i_param = {4'(in_len - 1), 3'(out_len - 1)};
        for (int i = 0; i < in_len; i++) begin
            if (i == gap_at) begin
                ena = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check({tag, ".gap_in_ready"}, int'(o_in_ready), 0);
                end
                check({tag, ".gap_busy"}, int'(o_busy), 1);
                ena = 1'b1;
            end
            send(tag, xv[i]);
        end
        check({tag, ".valid_after_t"}, int'(o_valid), 0);
        @(negedge clk);
        check({tag, ".valid_after_t1"}, int'(o_valid), 1);
        for (int k = 0; k < out_len; k++) begin
            n = 0;
            while (!o_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (n >= 20) check({tag, ".drain_timeout"}, 0, 1);
            if (k == stall_col) begin
                i_out_ready = 1'b0;
                held = o_data;
                repeat (3) begin
                    @(negedge clk);
                    check({tag, ".stall_valid"}, int'(o_valid), 1);
                    check({tag, ".stall_data"}, int'(o_data), int'(held));
                end
            end
            check($sformatf("%s.y%0d", tag, k), int'($signed(o_data)), exp_y[k]);
            check($sformatf("%s.last%0d", tag, k), int'(o_last), int'(k == out_len - 1));
            i_out_ready = 1'b1;
            @(negedge clk);
        end
        i_out_ready = 1'b0;
        check({tag, ".end_valid"}, int'(o_valid), 0);
        check({tag, ".end_busy"}, int'(o_busy), 0);
    endtask

    initial begin
        int il, ol, gap, stc;
        rst_n = 1'b0; ena = 1'b1; i_param = '0; i_weights = '0;
        i_weights_ready = 1'b1; i_data = '0; i_valid = 1'b0; i_out_ready = 1'b0;
        set_all(2'b00);
        repeat (2) @(negedge clk);
        check("rst.valid", int'(o_valid), 0);
        check("rst.last", int'(o_last), 0);
        check("rst.data", int'(o_data), 0);
        check("rst.busy", int'(o_busy), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Plain accumulate
        set_all(2'b01);
        xv[0] = 1; xv[1] = 2; xv[2] = 3; xv[3] = 4;
        run("accum", 4, 2, -1, -1);

        // Saturation both ways
        set_all(2'b00);
        for (int i = 0; i < MI; i++) begin
            wcode[i][0] = 2'b01; wcode[i][1] = 2'b11; xv[i] = -128;
        end
        run("sat", 16, 2, -1, -1);

        // Reserved code must not add
        set_all(2'b00);
        for (int i = 0; i < 2; i++) begin
            wcode[i][0] = 2'b10; wcode[i][1] = 2'b00; wcode[i][2] = 2'b11;
        end
        xv[0] = 5; xv[1] = 7;
        run("decode", 2, 3, -1, -1);

        // Gap mid-accumulate and drain back-pressure
        for (int i = 0; i < MI; i++)
            for (int j = 0; j < MO; j++) wcode[i][j] = 2'($urandom_range(0, 3));
        for (int i = 0; i < MI; i++) xv[i] = int'($urandom_range(0, 255)) - 128;
        run("flow", 6, 4, 3, 1);

        // Reset mid-run
        set_all(2'b01);
        pack_w();
        i_param = {4'd3, 3'd0};
        send("abort", 50);
        send("abort", 60);
        rst_n = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("abort.rst_valid", int'(o_valid), 0);
            check("abort.rst_busy", int'(o_busy), 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) xv[i] = 1;
        run("recover", 4, 1, -1, -1);

        // Weights not ready gates acceptance
        i_weights_ready = 1'b0;
        i_valid = 1'b1;
        i_data = 8'd9;
        repeat (3) begin
            #1;
            check("gate.in_ready", int'(o_in_ready), 0);
            @(negedge clk);
        end
        check("gate.busy", int'(o_busy), 0);
        i_valid = 1'b0;
        i_weights_ready = 1'b1;

        // Minimal 1x1 run
        set_all(2'b00);
        wcode[0][0] = 2'b11;
        xv[0] = 9;
        run("min", 1, 1, -1, -1);

        // Randomized runs
        for (int r = 0; r < 25; r++) begin
            il = $urandom_range(1, MI);
            ol = $urandom_range(1, MO);
            gap = (il > 1 && $urandom_range(0, 1) == 1) ? $urandom_range(1, il - 1) : -1;
            stc = ($urandom_range(0, 1) == 1) ? $urandom_range(0, ol - 1) : -1;
            for (int i = 0; i < MI; i++)
                for (int j = 0; j < MO; j++) wcode[i][j] = 2'($urandom_range(0, 3));
            for (int i = 0; i < MI; i++) xv[i] = int'($urandom_range(0, 255)) - 128;
            run($sformatf("rnd%0d", r), il, ol, gap, stc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
